// File: rtl/ifetch_if.sv
// Fetch-stage bundle: redirect/replay inputs, instruction-memory port and decode-facing outputs.
// The master side is the fetch stage; the slave side is its surrounding pipeline and memory.
interface ifetch_if;
  logic        EX_TakeBranch;
  logic [31:0] EX_BranchResult;
  logic        StallPc;
  logic [31:0] Pc_update;
  logic [31:0] Stalled_Instr;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Valid;
  logic [31:0] IMem_Rdata;
  logic [31:0] IF_Instr;
  logic [31:0] IF_Pc;
  logic [31:0] IF_Pc4;
  logic        NopIFInstr;

  modport master (
    input  EX_TakeBranch, EX_BranchResult, StallPc, Pc_update, Stalled_Instr,
    input  IMem_Valid, IMem_Rdata,
    output IMem_Req, IMem_Addr,
    output IF_Instr, IF_Pc, IF_Pc4, NopIFInstr
  );

  modport slave (
    output EX_TakeBranch, EX_BranchResult, StallPc, Pc_update, Stalled_Instr,
    output IMem_Valid, IMem_Rdata,
    input  IMem_Req, IMem_Addr,
    input  IF_Instr, IF_Pc, IF_Pc4, NopIFInstr
  );
endinterface

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one memory request in flight,
// and hands one instruction or bubble per cycle to decode, honouring redirects and replays.
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fpc_q, fpc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic              nop_q, nop_d;
  logic              issue_c;
  logic              squash_c;

  assign squash_c = bus.EX_TakeBranch | bus.StallPc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ISSUE;
      fpc_q   <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      nop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      nop_q   <= nop_d;
    end
  end

  // Next state, fetch PC and decode payload; a bubble is the default outcome.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    instr_d = NOP_INSTR;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    nop_d   = 1'b1;
    issue_c = 1'b0;

    if (squash_c) begin
      if (bus.EX_TakeBranch) begin
        fpc_d = {bus.EX_BranchResult[XLEN-1:2], 2'b00};
      end else begin
        fpc_d   = bus.Pc_update + XLEN'(4);
        instr_d = bus.Stalled_Instr;
        pc_d    = bus.Pc_update;
        pc4_d   = bus.Pc_update + XLEN'(4);
        nop_d   = 1'b0;
      end
      // An in-flight request whose response has not arrived must still be drained.
      unique case (state_q)
        S_ISSUE: state_d = S_ISSUE;
        S_WAIT,
        S_DROP:  state_d = bus.IMem_Valid ? S_ISSUE : S_DROP;
        default: state_d = S_ISSUE;
      endcase
    end else begin
      unique case (state_q)
        S_ISSUE: begin
          issue_c = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.IMem_Valid) begin
            instr_d = bus.IMem_Rdata;
            pc_d    = fpc_q;
            pc4_d   = fpc_q + XLEN'(4);
            nop_d   = 1'b0;
            fpc_d   = fpc_q + XLEN'(4);
            issue_c = 1'b1;
          end
        end
        S_DROP: begin
          if (bus.IMem_Valid) begin
            state_d = S_ISSUE;
          end
        end
        default: state_d = S_ISSUE;
      endcase
    end
  end

  // In WAIT the next request targets the instruction after the one being returned.
  assign bus.IMem_Addr  = (state_q == S_WAIT) ? fpc_q + XLEN'(4) : fpc_q;
  assign bus.IMem_Req   = issue_c & ~rst;
  assign bus.IF_Instr   = instr_q;
  assign bus.IF_Pc      = pc_q;
  assign bus.IF_Pc4     = pc4_q;
  assign bus.NopIFInstr = nop_q;
endmodule
